// File: rtl/id_ctrl_pipe_pkg.sv
// id_ctrl_pipe_pkg
//   Shared definitions for the ID-stage control pipe: opcode/funct constants,
//   ALU-op and destination codes, default bus widths, the FSM state type and
//   the packed control word that crosses the ID/EX boundary.
package id_ctrl_pipe_pkg;

    localparam int DEFAULT_OP_BUS_SIZE     = 6;
    localparam int DEFAULT_FUNCT_BUS_SIZE  = 6;
    localparam int DEFAULT_REG_ADDR_SIZE   = 5;
    localparam int DEFAULT_ALU_OP_BUS_SIZE = 3;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;
    localparam logic [2:0] ALU_XOR   = 3'b101;
    localparam logic [2:0] ALU_LUI   = 3'b110;
    localparam logic [2:0] ALU_SLT   = 3'b111;

    localparam logic [1:0] DEST_RT = 2'b00;
    localparam logic [1:0] DEST_RD = 2'b01;
    localparam logic [1:0] DEST_RA = 2'b10;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_e;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       branch_eq;
        logic       branch_ne;
        logic       jump;
        logic       jump_reg;
        logic       alu_src;
        logic [1:0] dest;
        logic [2:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    // R-type functs the EX-stage ALU actually implements (plus JR).
    function automatic logic r_funct_legal(input logic [5:0] funct);
        case (funct)
            6'b000000, 6'b000010, 6'b000011,                  // sll srl sra
            6'b000100, 6'b000110, 6'b000111,                  // sllv srlv srav
            6'b001000,                                        // jr
            6'b100000, 6'b100001, 6'b100010, 6'b100011,       // add addu sub subu
            6'b100100, 6'b100101, 6'b100110, 6'b100111,       // and or xor nor
            6'b101010, 6'b101011:                             // slt sltu
                return 1'b1;
            default:
                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/id_ctrl_pipe_hazard.sv
// id_hazard_unit
//   Combinational load-use detector. Flags when the load currently in EX
//   writes a register the ID instruction is about to read.
// Ports
//   i_ex_mem_read  EX instruction is a load
//   i_ex_rt        load destination register
//   i_rs, i_rt     ID source registers
//   i_uses_rt      ID instruction actually reads rt
//   o_hz           load-use hazard present
module id_hazard_unit #(
    parameter int REG_ADDR_SIZE = 5
) (
    input  logic                     i_ex_mem_read,
    input  logic [REG_ADDR_SIZE-1:0] i_ex_rt,
    input  logic [REG_ADDR_SIZE-1:0] i_rs,
    input  logic [REG_ADDR_SIZE-1:0] i_rt,
    input  logic                     i_uses_rt,
    output logic                     o_hz
);

    // $zero is never a real dependency, so a load into r0 never stalls.
    assign o_hz = i_ex_mem_read
                & (i_ex_rt != '0)
                & ((i_ex_rt == i_rs) | ((i_ex_rt == i_rt) & i_uses_rt));

endmodule

// File: rtl/id_ctrl_pipe.sv
// id_ctrl_pipe
//   ID-stage control: decodes op/funct, detects load-use hazards, and
//   registers the control word into the ID/EX boundary. Stall, flush and the
//   HALTED state all turn the issued word into a bubble (all zero).
//   Optional build macro ID_CTRL_ILLEGAL_TRAP_EN: unlisted opcodes and
//   unsupported R functs bubble, set sticky o_illegal and halt the pipe.
//
//   FSM states
//   state     | meaning
//   ST_RUN    | normal decode/issue
//   ST_HALTED | HALT (or trap) seen; only bubbles issued until reset
//
// Ports
//   i_clk, i_reset           clock, synchronous active-high reset
//   i_enable                 pipeline advance; 0 holds every register
//   i_flush                  kill the instruction currently in ID
//   i_op, i_funct            instruction fields from IF/ID
//   i_rs, i_rt               source register addresses from IF/ID
//   i_ex_mem_read, i_ex_rt   load currently in EX and its destination
//   o_stall                  combinational hold for PC and IF/ID
//   o_halted                 sticky HALTED indication
//   o_illegal                (trap build only) sticky illegal-instruction flag
//   o_ex_*                   registered ID/EX control word
module id_ctrl_pipe
    import id_ctrl_pipe_pkg::*;
#(
    parameter int OP_BUS_SIZE     = DEFAULT_OP_BUS_SIZE,
    parameter int FUNCT_BUS_SIZE  = DEFAULT_FUNCT_BUS_SIZE,
    parameter int REG_ADDR_SIZE   = DEFAULT_REG_ADDR_SIZE,
    parameter int ALU_OP_BUS_SIZE = DEFAULT_ALU_OP_BUS_SIZE
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_enable,
    input  logic                       i_flush,
    input  logic [OP_BUS_SIZE-1:0]     i_op,
    input  logic [FUNCT_BUS_SIZE-1:0]  i_funct,
    input  logic [REG_ADDR_SIZE-1:0]   i_rs,
    input  logic [REG_ADDR_SIZE-1:0]   i_rt,
    input  logic                       i_ex_mem_read,
    input  logic [REG_ADDR_SIZE-1:0]   i_ex_rt,
    output logic                       o_stall,
    output logic                       o_halted,
`ifdef ID_CTRL_ILLEGAL_TRAP_EN
    output logic                       o_illegal,
`endif
    output logic                       o_ex_reg_write,
    output logic                       o_ex_mem_to_reg,
    output logic                       o_ex_mem_read,
    output logic                       o_ex_mem_write,
    output logic                       o_ex_branch_eq,
    output logic                       o_ex_branch_ne,
    output logic                       o_ex_jump,
    output logic                       o_ex_jump_reg,
    output logic                       o_ex_alu_src,
    output logic [1:0]                 o_ex_dest,
    output logic [ALU_OP_BUS_SIZE-1:0] o_ex_alu_op
);

    state_e state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d;
    ctrl_t  dec;
    logic   uses_rt;
    logic   is_halt;
    logic   trap_hit;
    logic   hz;
    logic   advance;

`ifdef ID_CTRL_ILLEGAL_TRAP_EN
    logic   illegal_op;
    logic   illegal_q, illegal_d;
`endif

    // ---------------- decode ----------------
    always_comb begin
        dec     = CTRL_BUBBLE;
        uses_rt = 1'b0;
        is_halt = 1'b0;
`ifdef ID_CTRL_ILLEGAL_TRAP_EN
        illegal_op = 1'b0;
`endif
        case (i_op)
            OP_RTYPE: begin
                uses_rt = 1'b1;
                if (i_funct == FN_JR) begin
                    dec.jump_reg = 1'b1;
                end else begin
                    dec.reg_write = 1'b1;
                    dec.dest      = DEST_RD;
                    dec.alu_op    = ALU_FUNCT;
                end
`ifdef ID_CTRL_ILLEGAL_TRAP_EN
                illegal_op = ~r_funct_legal(i_funct);
`endif
            end
            OP_LW: begin
                dec.mem_read   = 1'b1;
                dec.reg_write  = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.alu_src    = 1'b1;
                dec.alu_op     = ALU_ADD;
                dec.dest       = DEST_RT;
            end
            OP_SW: begin
                uses_rt       = 1'b1;
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_op    = ALU_ADD;
            end
            OP_BEQ: begin
                uses_rt       = 1'b1;
                dec.branch_eq = 1'b1;
                dec.alu_op    = ALU_SUB;
            end
            OP_BNE: begin
                uses_rt       = 1'b1;
                dec.branch_ne = 1'b1;
                dec.alu_op    = ALU_SUB;
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.dest      = DEST_RT;
                case (i_op)
                    OP_SLTI: dec.alu_op = ALU_SLT;
                    OP_ANDI: dec.alu_op = ALU_AND;
                    OP_ORI:  dec.alu_op = ALU_OR;
                    OP_XORI: dec.alu_op = ALU_XOR;
                    OP_LUI:  dec.alu_op = ALU_LUI;
                    default: dec.alu_op = ALU_ADD;
                endcase
            end
            OP_J: begin
                dec.jump = 1'b1;
            end
            OP_JAL: begin
                dec.jump      = 1'b1;
                dec.reg_write = 1'b1;
                dec.dest      = DEST_RA;
            end
            OP_HALT: begin
                is_halt = 1'b1;
            end
            default: begin
`ifdef ID_CTRL_ILLEGAL_TRAP_EN
                illegal_op = 1'b1;
`endif
            end
        endcase
    end

`ifdef ID_CTRL_ILLEGAL_TRAP_EN
    assign trap_hit = illegal_op;
`else
    assign trap_hit = 1'b0;
`endif

    id_hazard_unit #(
        .REG_ADDR_SIZE (REG_ADDR_SIZE)
    ) u_hazard (
        .i_ex_mem_read (i_ex_mem_read),
        .i_ex_rt       (i_ex_rt),
        .i_rs          (i_rs),
        .i_rt          (i_rt),
        .i_uses_rt     (uses_rt),
        .o_hz          (hz)
    );

    // A flush already discards the ID instruction, so holding it would be wasted.
    assign o_stall = hz & ~i_flush & (state_q == ST_RUN);

    // The ID instruction really takes effect this edge.
    assign advance = i_enable & ~i_flush & ~o_stall & (state_q == ST_RUN);

    // ---------------- state register ----------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_RUN;
            ctrl_q  <= CTRL_BUBBLE;
`ifdef ID_CTRL_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
`ifdef ID_CTRL_ILLEGAL_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        if (advance & (is_halt | trap_hit)) begin
            state_d = ST_HALTED;
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        ctrl_d = ctrl_q;
        if (i_enable) begin
            if (advance & ~is_halt & ~trap_hit) begin
                ctrl_d = dec;
            end else begin
                ctrl_d = CTRL_BUBBLE;
            end
        end
    end

`ifdef ID_CTRL_ILLEGAL_TRAP_EN
    assign illegal_d = illegal_q | (advance & trap_hit);
    assign o_illegal = illegal_q;
`endif

    assign o_halted        = (state_q == ST_HALTED);
    assign o_ex_reg_write  = ctrl_q.reg_write;
    assign o_ex_mem_to_reg = ctrl_q.mem_to_reg;
    assign o_ex_mem_read   = ctrl_q.mem_read;
    assign o_ex_mem_write  = ctrl_q.mem_write;
    assign o_ex_branch_eq  = ctrl_q.branch_eq;
    assign o_ex_branch_ne  = ctrl_q.branch_ne;
    assign o_ex_jump       = ctrl_q.jump;
    assign o_ex_jump_reg   = ctrl_q.jump_reg;
    assign o_ex_alu_src    = ctrl_q.alu_src;
    assign o_ex_dest       = ctrl_q.dest;
    assign o_ex_alu_op     = ctrl_q.alu_op;

endmodule

// File: tb/tb_id_ctrl_pipe.sv
// tb_id_ctrl_pipe
//   Directed scenarios followed by random traffic, all checked against a
//   table-driven reference model of the ID stage.
module tb_id_ctrl_pipe;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_enable = 1'b0;
    logic       i_flush = 1'b0;
    logic [5:0] i_op = '0;
    logic [5:0] i_funct = '0;
    logic [4:0] i_rs = '0;
    logic [4:0] i_rt = '0;
    logic       i_ex_mem_read = 1'b0;
    logic [4:0] i_ex_rt = '0;
    logic       o_stall, o_halted;
    logic       o_ex_reg_write, o_ex_mem_to_reg, o_ex_mem_read, o_ex_mem_write;
    logic       o_ex_branch_eq, o_ex_branch_ne, o_ex_jump, o_ex_jump_reg, o_ex_alu_src;
    logic [1:0] o_ex_dest;
    logic [2:0] o_ex_alu_op;
`ifdef ID_CTRL_ILLEGAL_TRAP_EN
    logic       o_illegal;
`endif

    always #5 i_clk = ~i_clk;

    id_ctrl_pipe dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_enable        (i_enable),
        .i_flush         (i_flush),
        .i_op            (i_op),
        .i_funct         (i_funct),
        .i_rs            (i_rs),
        .i_rt            (i_rt),
        .i_ex_mem_read   (i_ex_mem_read),
        .i_ex_rt         (i_ex_rt),
        .o_stall         (o_stall),
        .o_halted        (o_halted),
`ifdef ID_CTRL_ILLEGAL_TRAP_EN
        .o_illegal       (o_illegal),
`endif
        .o_ex_reg_write  (o_ex_reg_write),
        .o_ex_mem_to_reg (o_ex_mem_to_reg),
        .o_ex_mem_read   (o_ex_mem_read),
        .o_ex_mem_write  (o_ex_mem_write),
        .o_ex_branch_eq  (o_ex_branch_eq),
        .o_ex_branch_ne  (o_ex_branch_ne),
        .o_ex_jump       (o_ex_jump),
        .o_ex_jump_reg   (o_ex_jump_reg),
        .o_ex_alu_src    (o_ex_alu_src),
        .o_ex_dest       (o_ex_dest),
        .o_ex_alu_op     (o_ex_alu_op)
    );

    logic [13:0] obs_word;
    assign obs_word = {o_ex_reg_write, o_ex_mem_to_reg, o_ex_mem_read, o_ex_mem_write,
                       o_ex_branch_eq, o_ex_branch_ne, o_ex_jump, o_ex_jump_reg,
                       o_ex_alu_src, o_ex_dest, o_ex_alu_op};

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [13:0] m_word = '0;
    logic        m_halted = 1'b0;
    logic        m_illegal = 1'b0;

    logic [5:0] legal_ops [13] = '{6'o00, 6'o02, 6'o03, 6'o04, 6'o05, 6'o10, 6'o12,
                                   6'o14, 6'o15, 6'o16, 6'o17, 6'o43, 6'o53};

    function automatic logic [13:0] cw(input logic rw, m2r, mr, mw, beq, bne, j, jr, src,
                                       input logic [1:0] dest, input logic [2:0] alu);
        return {rw, m2r, mr, mw, beq, bne, j, jr, src, dest, alu};
    endfunction

    function automatic logic [13:0] ref_decode(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'b000000: return (fn == 6'b001000) ? cw(0,0,0,0,0,0,0,1,0,2'd0,3'd0)
                                                : cw(1,0,0,0,0,0,0,0,0,2'd1,3'd2);
            6'b100011: return cw(1,1,1,0,0,0,0,0,1,2'd0,3'd0);
            6'b101011: return cw(0,0,0,1,0,0,0,0,1,2'd0,3'd0);
            6'b000100: return cw(0,0,0,0,1,0,0,0,0,2'd0,3'd1);
            6'b000101: return cw(0,0,0,0,0,1,0,0,0,2'd0,3'd1);
            6'b001000: return cw(1,0,0,0,0,0,0,0,1,2'd0,3'd0);
            6'b001010: return cw(1,0,0,0,0,0,0,0,1,2'd0,3'd7);
            6'b001100: return cw(1,0,0,0,0,0,0,0,1,2'd0,3'd3);
            6'b001101: return cw(1,0,0,0,0,0,0,0,1,2'd0,3'd4);
            6'b001110: return cw(1,0,0,0,0,0,0,0,1,2'd0,3'd5);
            6'b001111: return cw(1,0,0,0,0,0,0,0,1,2'd0,3'd6);
            6'b000010: return cw(0,0,0,0,0,0,1,0,0,2'd0,3'd0);
            6'b000011: return cw(1,0,0,0,0,0,1,0,0,2'd2,3'd0);
            default:   return 14'd0;
        endcase
    endfunction

    function automatic logic ref_hz(input logic [5:0] op, input logic [4:0] rs, rt,
                                    input logic exmr, input logic [4:0] exrt);
        logic reads_rt;
        reads_rt = (op == 6'b000000) || (op == 6'b000100) || (op == 6'b000101) || (op == 6'b101011);
        return exmr && (exrt != 5'd0) && ((exrt == rs) || ((exrt == rt) && reads_rt));
    endfunction

`ifdef ID_CTRL_ILLEGAL_TRAP_EN
    function automatic logic ref_illegal(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'b111111) return 1'b0;
        if (!(op inside {6'o00, 6'o02, 6'o03, 6'o04, 6'o05, 6'o10, 6'o12,
                         6'o14, 6'o15, 6'o16, 6'o17, 6'o43, 6'o53})) return 1'b1;
        if (op == 6'b000000)
            return !(fn inside {6'o00, 6'o02, 6'o03, 6'o04, 6'o06, 6'o07, 6'o10,
                                6'o40, 6'o41, 6'o42, 6'o43, 6'o44, 6'o45, 6'o46, 6'o47,
                                6'o52, 6'o53});
        return 1'b0;
    endfunction
`endif

    task automatic model_edge(input logic rst, en, fl, stall, input logic [5:0] op, fn);
        if (rst) begin
            m_word = '0; m_halted = 1'b0; m_illegal = 1'b0;
        end else if (en) begin
            if (fl || stall || m_halted) begin
                m_word = '0;
            end else if (op == 6'b111111) begin
                m_word = '0; m_halted = 1'b1;
            end else begin
                m_word = ref_decode(op, fn);
`ifdef ID_CTRL_ILLEGAL_TRAP_EN
                if (ref_illegal(op, fn)) begin
                    m_word = '0; m_halted = 1'b1; m_illegal = 1'b1;
                end
`endif
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic rst, en, fl,
                        input logic [5:0] op, fn, input logic [4:0] rs, rt,
                        input logic exmr, input logic [4:0] exrt);
        logic exp_stall;
        i_reset = rst; i_enable = en; i_flush = fl; i_op = op; i_funct = fn;
        i_rs = rs; i_rt = rt; i_ex_mem_read = exmr; i_ex_rt = exrt;
        #1;
        exp_stall = ref_hz(op, rs, rt, exmr, exrt) && !fl && !m_halted;
        check({tag, "/stall"}, 32'(o_stall), 32'(exp_stall));
        model_edge(rst, en, fl, exp_stall, op, fn);
        @(posedge i_clk);
        #1;
        check({tag, "/ctrl"}, 32'(obs_word), 32'(m_word));
        check({tag, "/halted"}, 32'(o_halted), 32'(m_halted));
`ifdef ID_CTRL_ILLEGAL_TRAP_EN
        check({tag, "/illegal"}, 32'(o_illegal), 32'(m_illegal));
`endif
    endtask

    initial begin
        logic [5:0] r_op, r_fn;
        int sel;

        // reset state
        step("reset0", 1, 0, 0, 6'o00, 6'o00, 5'd0, 5'd0, 0, 5'd0);
        step("reset1", 1, 1, 0, 6'o00, 6'o00, 5'd0, 5'd0, 0, 5'd0);

        // reset right after a LW has been issued
        step("lw_pre_rst", 0, 1, 0, 6'b100011, 6'o00, 5'd1, 5'd5, 0, 5'd0);
        step("rst_mid",    1, 1, 0, 6'b001000, 6'o00, 5'd1, 5'd2, 0, 5'd0);

        // LW followed by dependent ADDU: one stall cycle, then ADDU issues
        step("lw",         0, 1, 0, 6'b100011, 6'o00, 5'd1, 5'd5, 0, 5'd0);
        step("addu_stall", 0, 1, 0, 6'b000000, 6'b100001, 5'd5, 5'd2, 1, 5'd5);
        step("addu_issue", 0, 1, 0, 6'b000000, 6'b100001, 5'd5, 5'd2, 0, 5'd0);

        // load into r0 never stalls; rt match on an I-type that does not read rt
        step("exrt_zero",  0, 1, 0, 6'b000000, 6'b100001, 5'd0, 5'd0, 1, 5'd0);
        step("rt_unused",  0, 1, 0, 6'b001101, 6'o00, 5'd3, 5'd7, 1, 5'd7);
        step("rt_used_sw", 0, 1, 0, 6'b101011, 6'o00, 5'd3, 5'd7, 1, 5'd7);

        // stall and flush together: flush wins, bubble, no hold
        step("stall_flush", 0, 1, 1, 6'b000100, 6'o00, 5'd4, 5'd6, 1, 5'd6);

        // enable low for 3 cycles around BEQ
        step("ori_pre",  0, 1, 0, 6'b001101, 6'o00, 5'd1, 5'd2, 0, 5'd0);
        step("hold0",    0, 0, 0, 6'b000100, 6'o00, 5'd1, 5'd2, 0, 5'd0);
        step("hold1",    0, 0, 1, 6'b000100, 6'o00, 5'd1, 5'd2, 0, 5'd0);
        step("hold2",    0, 0, 0, 6'b000100, 6'o00, 5'd1, 5'd2, 0, 5'd0);
        step("beq_go",   0, 1, 0, 6'b000100, 6'o00, 5'd1, 5'd2, 0, 5'd0);

        // flushed or stalled HALT must not halt
        step("halt_flush", 0, 1, 1, 6'b111111, 6'o00, 5'd0, 5'd0, 0, 5'd0);
        step("halt_stall", 0, 1, 0, 6'b111111, 6'o00, 5'd9, 5'd0, 1, 5'd9);
        step("jal",        0, 1, 0, 6'b000011, 6'o00, 5'd0, 5'd0, 0, 5'd0);

        // HALT, then bubbles until reset; no stall while halted
        step("halt",       0, 1, 0, 6'b111111, 6'o00, 5'd0, 5'd0, 0, 5'd0);
        step("halted_addi0", 0, 1, 0, 6'b001000, 6'o00, 5'd1, 5'd2, 0, 5'd0);
        step("halted_hz",    0, 1, 0, 6'b000000, 6'b100001, 5'd3, 5'd2, 1, 5'd3);
        step("halted_addi1", 0, 1, 0, 6'b001000, 6'o00, 5'd1, 5'd2, 0, 5'd0);
        step("halt_rst",     1, 1, 0, 6'b001000, 6'o00, 5'd1, 5'd2, 0, 5'd0);
        step("after_rst",    0, 1, 0, 6'b001000, 6'o00, 5'd1, 5'd2, 0, 5'd0);

        // unlisted opcode
        step("unlisted",     0, 1, 0, 6'b111110, 6'o00, 5'd1, 5'd2, 0, 5'd0);
        step("post_unlisted", 0, 1, 0, 6'b001111, 6'o00, 5'd1, 5'd2, 0, 5'd0);
        step("rst2",         1, 1, 0, 6'o00, 6'o00, 5'd0, 5'd0, 0, 5'd0);

        // random traffic
        for (int n = 0; n < 500; n++) begin
            sel = $urandom_range(0, 99);
            if (sel < 80)      r_op = legal_ops[$urandom_range(0, 12)];
            else if (sel < 84) r_op = 6'b111111;
            else               r_op = 6'($urandom);
            sel = $urandom_range(0, 9);
            if (sel < 5)       r_fn = 6'b100001;
            else if (sel < 7)  r_fn = 6'b001000;
            else               r_fn = 6'($urandom);
            step("rand",
                 ($urandom_range(0, 99) < 3) || (m_halted && $urandom_range(0, 9) == 0),
                 $urandom_range(0, 99) < 85,
                 $urandom_range(0, 99) < 15,
                 r_op, r_fn,
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
